// File: rtl/key_event_sched_if.sv
// Event stream between the key scheduler and its consumer.
// The master drives the event; the slave drives ready.
interface key_event_sched_if #(
    parameter int unsigned KW = 2
);
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_key;
    logic [1:0]    evt_code;

    modport master (output evt_valid, output evt_key, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_key, input evt_code, output evt_ready);
endinterface

// File: rtl/key_event_sched.sv
// Classifies per-key press/release pulses as short/long presses and serialises
// the resulting events onto one valid/ready stream with round-robin arbitration.
module key_event_sched #(
    parameter int unsigned N_KEYS   = 4,
    parameter int unsigned LONG_CYC = 50000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_KEYS-1:0]    i_press,
    input  logic [N_KEYS-1:0]    i_release,
    key_event_sched_if.master    evt,
    output logic [N_KEYS-1:0]    o_overflow,
    input  logic                 i_ovf_clr
);
    localparam int unsigned KW = $clog2(N_KEYS);
    localparam int unsigned CW = $clog2(LONG_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LONG_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;
    typedef enum logic [1:0] {
        EVT_PRESS     = 2'd0,
        EVT_REL_SHORT = 2'd1,
        EVT_LONG      = 2'd2,
        EVT_REL_LONG  = 2'd3
    } evt_code_t;

    state_t            r_state     [N_KEYS];
    state_t            w_state_nxt [N_KEYS];
    logic [CW-1:0]     r_cnt       [N_KEYS];
    logic [CW-1:0]     w_cnt_nxt   [N_KEYS];
    logic [N_KEYS-1:0] w_post;
    evt_code_t         w_post_code [N_KEYS];

    logic [N_KEYS-1:0] r_slot_vld;
    evt_code_t         r_slot_code [N_KEYS];
    logic [N_KEYS-1:0] w_ovf_set;
    logic [N_KEYS-1:0] r_ovf;

    logic              r_valid;
    logic [KW-1:0]     r_key;
    evt_code_t         r_code;
    logic [KW-1:0]     r_ptr;

    logic              w_load;
    logic              w_found;
    logic              w_fire;
    logic [KW-1:0]     w_gnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                r_state[k] <= S_IDLE;
                r_cnt[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_cnt[k]   <= w_cnt_nxt[k];
            end
        end
    end

    // A release always takes priority over a simultaneous press or LONG timeout.
    always_comb begin
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            w_state_nxt[k] = r_state[k];
            w_cnt_nxt[k]   = r_cnt[k];
            w_post[k]      = 1'b0;
            w_post_code[k] = EVT_PRESS;
            case (r_state[k])
                S_IDLE: begin
                    if (i_press[k] && !i_release[k]) begin
                        w_state_nxt[k] = S_HELD;
                        w_cnt_nxt[k]   = '0;
                        w_post[k]      = 1'b1;
                        w_post_code[k] = EVT_PRESS;
                    end
                end
                S_HELD: begin
                    if (i_release[k]) begin
                        w_state_nxt[k] = S_IDLE;
                        w_cnt_nxt[k]   = '0;
                        w_post[k]      = 1'b1;
                        w_post_code[k] = EVT_REL_SHORT;
                    end else if (r_cnt[k] == CNT_LAST) begin
                        w_state_nxt[k] = S_LONG;
                        w_post[k]      = 1'b1;
                        w_post_code[k] = EVT_LONG;
                    end else begin
                        w_cnt_nxt[k] = r_cnt[k] + CW'(1);
                    end
                end
                S_LONG: begin
                    if (i_release[k]) begin
                        w_state_nxt[k] = S_IDLE;
                        w_cnt_nxt[k]   = '0;
                        w_post[k]      = 1'b1;
                        w_post_code[k] = EVT_REL_LONG;
                    end
                end
                default: w_state_nxt[k] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        int unsigned idx;
        w_load  = !r_valid || evt.evt_ready;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            idx = (32'(r_ptr) + i) % N_KEYS;
            if (!w_found && r_slot_vld[idx]) begin
                w_found = 1'b1;
                w_gnt   = KW'(idx);
            end
        end
        w_fire = w_load && w_found;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            w_ovf_set[k] = w_post[k] && r_slot_vld[k] && !(w_fire && w_gnt == KW'(k));
        end
    end

    // A slot being granted this cycle is free to accept a new post.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_vld <= '0;
            for (int unsigned k = 0; k < N_KEYS; k++) r_slot_code[k] <= EVT_PRESS;
            r_ovf   <= '0;
            r_valid <= 1'b0;
            r_key   <= '0;
            r_code  <= EVT_PRESS;
            r_ptr   <= '0;
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                if (w_post[k] && !w_ovf_set[k]) begin
                    r_slot_vld[k]  <= 1'b1;
                    r_slot_code[k] <= w_post_code[k];
                end else if (w_fire && w_gnt == KW'(k)) begin
                    r_slot_vld[k] <= 1'b0;
                end
            end
            r_ovf <= (i_ovf_clr ? '0 : r_ovf) | w_ovf_set;
            if (w_load) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_key   <= w_gnt;
                    r_code  <= r_slot_code[w_gnt];
                    r_ptr   <= (w_gnt == KW'(N_KEYS - 1)) ? '0 : w_gnt + KW'(1);
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign evt.evt_valid = r_valid;
    assign evt.evt_key   = r_key;
    assign evt.evt_code  = r_code;
    assign o_overflow    = r_ovf;
endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: an event-level model checked every cycle,
// plus literal expectations at hand-computed cycles.
module tb_key_event_sched;
    localparam int N = 4;
    localparam int LC = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] press = '0;
    logic [N-1:0] release_p = '0;
    logic         ready = 1'b1;
    logic         clr = 1'b0;
    logic [N-1:0] ovf;

    int n_chk = 0;
    int n_fail = 0;

    key_event_sched_if #(.KW(2)) u_if ();
    assign u_if.evt_ready = ready;

    key_event_sched #(.N_KEYS(N), .LONG_CYC(LC)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_press    (press),
        .i_release  (release_p),
        .evt        (u_if),
        .o_overflow (ovf),
        .i_ovf_clr  (clr)
    );

    always #5 clk = ~clk;

    // Event-level model: keys remember their press time, slots hold a code or -1.
    int m_press_t [N];
    bit m_held    [N];
    bit m_long    [N];
    int m_slot    [N];
    int m_post    [N];
    bit m_valid;
    int m_key, m_code, m_ptr, m_gnt, cyc;
    bit m_acc;
    bit [N-1:0] m_ovf, m_set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_held[k] = 0; m_long[k] = 0; m_slot[k] = -1; m_press_t[k] = 0;
            end
            m_valid = 0; m_key = 0; m_code = 0; m_ptr = 0; m_ovf = '0; cyc = 0;
        end else begin
            m_acc = !m_valid || ready;
            m_gnt = -1;
            if (m_acc)
                for (int i = 0; i < N; i++)
                    if (m_gnt < 0 && m_slot[(m_ptr + i) % N] >= 0) m_gnt = (m_ptr + i) % N;
            for (int k = 0; k < N; k++) begin
                m_post[k] = -1;
                if (m_held[k]) begin
                    if (release_p[k]) begin
                        m_post[k] = m_long[k] ? 3 : 1;
                        m_held[k] = 0;
                        m_long[k] = 0;
                    end else if (!m_long[k] && cyc - m_press_t[k] == LC) begin
                        m_post[k] = 2;
                        m_long[k] = 1;
                    end
                end else if (press[k] && !release_p[k]) begin
                    m_held[k] = 1;
                    m_press_t[k] = cyc;
                    m_post[k] = 0;
                end
            end
            if (m_acc) begin
                if (m_gnt >= 0) begin
                    m_valid = 1; m_key = m_gnt; m_code = m_slot[m_gnt];
                    m_slot[m_gnt] = -1; m_ptr = (m_gnt + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
            m_set = '0;
            for (int k = 0; k < N; k++)
                if (m_post[k] >= 0) begin
                    if (m_slot[k] < 0) m_slot[k] = m_post[k];
                    else m_set[k] = 1'b1;
                end
            if (clr) m_ovf = '0;
            m_ovf = m_ovf | m_set;
            cyc++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_valid", int'(u_if.evt_valid), int'(m_valid));
        if (m_valid) begin
            check("model_key", int'(u_if.evt_key), m_key);
            check("model_code", int'(u_if.evt_code), m_code);
        end
        check("model_ovf", int'(ovf), int'(m_ovf));
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int c, input logic [N-1:0] p, input logic [N-1:0] r, input logic cl);
        at_cycle(c);
        press = p; release_p = r; clr = cl;
        @(posedge clk);
        #1;
        press = '0; release_p = '0; clr = 1'b0;
    endtask

    task automatic lit(input int c, input string name, input int v, input int k, input int code, input int ov);
        at_cycle(c);
        #1;
        check({name, "_valid"}, int'(u_if.evt_valid), v);
        if (v != 0) begin
            check({name, "_key"}, int'(u_if.evt_key), k);
            check({name, "_code"}, int'(u_if.evt_code), code);
        end
        if (ov >= 0) check({name, "_ovf"}, int'(ovf), ov);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; press = '0; release_p = '0; clr = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Short press on key1
        do_reset();
        lit(0, "reset", 0, 0, 0, 0);
        drive(10, 4'b0010, '0, 0);
        lit(11, "s1_lat", 0, 0, 0, -1);
        lit(12, "s1_press", 1, 1, 0, -1);
        drive(50, '0, 4'b0010, 0);
        lit(52, "s1_rel", 1, 1, 1, -1);
        lit(53, "s1_idle", 0, 0, 0, -1);
        lit(120, "s1_nolong", 0, 0, 0, 0);

        // Long press on key2
        do_reset();
        drive(10, 4'b0100, '0, 0);
        lit(12, "s2_press", 1, 2, 0, -1);
        lit(111, "s2_prelong", 0, 0, 0, -1);
        lit(112, "s2_long", 1, 2, 2, -1);
        drive(300, '0, 4'b0100, 0);
        lit(302, "s2_rel", 1, 2, 3, -1);

        // Round-robin from pointer 0, then from pointer 2
        do_reset();
        drive(5, 4'b1111, '0, 0);
        for (int i = 0; i < 4; i++) lit(7 + i, "s3_rr0", 1, i, 0, -1);
        lit(11, "s3_drain", 0, 0, 0, -1);
        drive(20, '0, 4'b1111, 0);
        for (int i = 0; i < 4; i++) lit(22 + i, "s3_rel", 1, i, 1, -1);
        drive(30, 4'b0010, '0, 0);
        drive(34, '0, 4'b0010, 0);
        drive(40, 4'b1111, '0, 0);
        for (int i = 0; i < 4; i++) lit(42 + i, "s3_rr2", 1, (2 + i) % 4, 0, -1);

        // Backpressure, overflow, clear, set-wins-over-clear
        do_reset();
        ready = 1'b0;
        drive(10, 4'b0001, '0, 0);
        drive(15, '0, 4'b0001, 0);
        lit(20, "s4_hold", 1, 0, 0, 0);
        drive(22, 4'b0001, '0, 0);
        drive(24, '0, 4'b0001, 0);
        lit(25, "s4_ovf", 1, 0, 0, 1);
        at_cycle(30);
        ready = 1'b1;
        lit(31, "s4_rel", 1, 0, 1, 1);
        lit(32, "s4_empty", 0, 0, 0, 1);
        drive(35, '0, '0, 1);
        lit(36, "s4_clr", 0, 0, 0, 0);
        at_cycle(40);
        ready = 1'b0;
        drive(40, 4'b0001, '0, 0);
        drive(44, '0, 4'b0001, 0);
        drive(46, 4'b0001, '0, 0);
        lit(47, "s4_ovf2", 1, 0, 0, 1);
        drive(48, '0, 4'b0001, 1);
        lit(49, "s4_setwins", 1, 0, 0, 1);
        drive(50, '0, '0, 1);
        lit(51, "s4_clr2", 1, 0, 0, 0);
        at_cycle(52);
        ready = 1'b1;
        lit(53, "s4_rel2", 1, 0, 1, 0);
        lit(54, "s4_empty2", 0, 0, 0, 0);

        // Same-cycle press+release and spurious release
        do_reset();
        drive(10, 4'b1000, 4'b1000, 0);
        lit(12, "s5_pr", 0, 0, 0, 0);
        drive(15, '0, 4'b1000, 0);
        lit(17, "s5_spur", 0, 0, 0, 0);
        lit(25, "s5_quiet", 0, 0, 0, 0);

        // Reset while holding an event with key0 in LONG
        do_reset();
        ready = 1'b0;
        drive(10, 4'b0001, '0, 0);
        lit(115, "s6_held", 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_valid", int'(u_if.evt_valid), 0);
        check("s6_rst_key", int'(u_if.evt_key), 0);
        check("s6_rst_code", int'(u_if.evt_code), 0);
        check("s6_rst_ovf", int'(ovf), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready = 1'b1;
        drive(5, '0, 4'b0001, 0);
        lit(7, "s6_norel", 0, 0, 0, 0);
        lit(10, "s6_quiet", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
